// File: rtl/adder_arbiter.sv
// Shared WIDTH-bit adder arbitrated among NREQ requesters with a single-entry response slot.
// Define ADDARB_RR_EN for round-robin arbitration; default build is fixed priority (lowest index wins).
module adder_arbiter #(
  parameter int WIDTH = 32,
  parameter int NREQ  = 4,
  parameter int IDW   = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NREQ-1:0]       req_valid,
  output logic [NREQ-1:0]       req_ready,
  input  logic [NREQ*WIDTH-1:0] req_a,
  input  logic [NREQ*WIDTH-1:0] req_b,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [IDW-1:0]        rsp_id,
  output logic [WIDTH-1:0]      rsp_sum,
  output logic                  rsp_cout
);

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } state_e;

  state_e           state_q;
  logic [IDW-1:0]   id_q;
  logic [WIDTH-1:0] sum_q;
  logic             cout_q;

  logic [IDW-1:0]   start_s;
  logic [IDW-1:0]   idx_s;
  logic [NREQ-1:0]  grant_s;
  logic [IDW-1:0]   gnt_idx_s;
  logic [WIDTH-1:0] a_sel_s;
  logic [WIDTH-1:0] b_sel_s;
  logic             any_valid_s;
  logic             can_accept_s;
  logic             accept_s;
  logic [WIDTH:0]   sum_d;

`ifdef ADDARB_RR_EN
  logic [IDW-1:0]   ptr_q;
  logic [IDW-1:0]   ptr_d;

  assign start_s = ptr_q;
  assign ptr_d   = (gnt_idx_s == IDW'(NREQ - 1)) ? '0 : gnt_idx_s + IDW'(1);
`else
  assign start_s = '0;
`endif

  // Search from start_s upward with wrap; the first valid requester wins and drives the adder.
  always_comb begin
    grant_s     = '0;
    gnt_idx_s   = '0;
    a_sel_s     = '0;
    b_sel_s     = '0;
    any_valid_s = 1'b0;
    idx_s       = '0;
    for (int k = 0; k < NREQ; k++) begin
      idx_s = IDW'((int'(start_s) + k) % NREQ);
      if (!any_valid_s && req_valid[idx_s]) begin
        any_valid_s = 1'b1;
        gnt_idx_s   = idx_s;
        grant_s     = NREQ'(1) << idx_s;
        a_sel_s     = req_a[int'(idx_s)*WIDTH +: WIDTH];
        b_sel_s     = req_b[int'(idx_s)*WIDTH +: WIDTH];
      end else begin
        any_valid_s = any_valid_s;
      end
    end
  end

  assign can_accept_s = (state_q == ST_EMPTY) || rsp_ready;
  assign accept_s     = any_valid_s && can_accept_s && rst_n;
  assign sum_d        = {1'b0, a_sel_s} + {1'b0, b_sel_s};

  // Ready is suppressed while reset is held, even though the slot looks empty then.
  always_comb begin
    if (rst_n && can_accept_s) begin
      req_ready = grant_s;
    end else begin
      req_ready = '0;
    end
  end

  // Slot state machine plus the response registers it guards.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_EMPTY;
      id_q    <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
`ifdef ADDARB_RR_EN
      ptr_q   <= '0;
`endif
    end else begin
      case (state_q)
        ST_EMPTY: state_q <= accept_s ? ST_FULL : ST_EMPTY;
        ST_FULL: begin
          if (accept_s) begin
            state_q <= ST_FULL;
          end else if (rsp_ready) begin
            state_q <= ST_EMPTY;
          end else begin
            state_q <= ST_FULL;
          end
        end
        default: state_q <= ST_EMPTY;
      endcase
      if (accept_s) begin
        id_q              <= gnt_idx_s;
        {cout_q, sum_q}   <= sum_d;
`ifdef ADDARB_RR_EN
        ptr_q             <= ptr_d;
`endif
      end
    end
  end

  assign rsp_valid = (state_q == ST_FULL);
  assign rsp_id    = id_q;
  assign rsp_sum   = sum_q;
  assign rsp_cout  = cout_q;

endmodule

// File: tb/tb_adder_arbiter.sv
// Directed bench for adder_arbiter: an arithmetic/queue-free reference model checked every
// cycle, plus hand-computed literal expectations. Honours ADDARB_RR_EN like the design.
module tb_adder_arbiter;
  localparam int WIDTH = 32;
  localparam int NREQ  = 4;
  localparam int IDW   = 2;
`ifdef ADDARB_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic                  clk = 1'b0;
  logic                  rst_n;
  logic [NREQ-1:0]       req_valid;
  logic [NREQ-1:0]       req_ready;
  logic [NREQ*WIDTH-1:0] req_a;
  logic [NREQ*WIDTH-1:0] req_b;
  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [IDW-1:0]        rsp_id;
  logic [WIDTH-1:0]      rsp_sum;
  logic                  rsp_cout;

  int n_checks = 0;
  int n_errors = 0;

  adder_arbiter #(.WIDTH(WIDTH), .NREQ(NREQ), .IDW(IDW)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_id(rsp_id), .rsp_sum(rsp_sum), .rsp_cout(rsp_cout)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model state: what the response slot must contain.
  int          m_ptr;
  bit          m_valid;
  int          m_id;
  logic [31:0] m_sum;
  bit          m_cout;

  function automatic int pick();
    int start;
    int idx;
    start = RR ? m_ptr : 0;
    for (int k = 0; k < NREQ; k++) begin
      idx = (start + k) % NREQ;
      if (req_valid[idx] === 1'b1) return idx;
    end
    return -1;
  endfunction

  function automatic logic [NREQ-1:0] exp_ready();
    int g;
    g = pick();
    if (rst_n !== 1'b1 || g < 0 || (m_valid && rsp_ready !== 1'b1)) return '0;
    return NREQ'(1) << g;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    int g;
    logic [63:0] t;
    if (!rst_n) begin
      m_valid <= 1'b0;
      m_ptr   <= 0;
      m_id    <= 0;
      m_sum   <= '0;
      m_cout  <= 1'b0;
    end else begin
      g = pick();
      if (g >= 0 && (!m_valid || rsp_ready)) begin
        t = 64'(req_a[g*WIDTH +: WIDTH]) + 64'(req_b[g*WIDTH +: WIDTH]);
        m_valid <= 1'b1;
        m_id    <= g;
        m_sum   <= t[31:0];
        m_cout  <= t[32];
        m_ptr   <= (g + 1) % NREQ;
      end else if (rsp_ready) begin
        m_valid <= 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    chk("model_req_ready", req_ready, exp_ready());
    chk("model_rsp_valid", rsp_valid, m_valid);
    if (m_valid) begin
      chk("model_rsp_id", rsp_id, m_id);
      chk("model_rsp_sum", rsp_sum, m_sum);
      chk("model_rsp_cout", rsp_cout, m_cout);
    end
  end

  task automatic set_op(input int i, input logic [31:0] a, input logic [31:0] b);
    req_a[i*WIDTH +: WIDTH] = a;
    req_b[i*WIDTH +: WIDTH] = b;
  endtask

  task automatic one_req(input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] es, input logic ec);
    @(posedge clk); #1;
    req_valid = 4'b0001;
    set_op(0, a, b);
    @(negedge clk);
    chk("single_ready", req_ready, 4'b0001);
    @(posedge clk); #1;
    req_valid = 4'b0000;
    @(negedge clk);
    chk("single_valid", rsp_valid, 1'b1);
    chk("single_id", rsp_id, 2'd0);
    chk("single_sum", rsp_sum, es);
    chk("single_cout", rsp_cout, ec);
  endtask

  initial begin
    rst_n     = 1'b1;
    req_valid = '0;
    req_a     = '0;
    req_b     = '0;
    rsp_ready = 1'b1;
    #1;
    rst_n     = 1'b0;
    req_valid = 4'b1111;
    @(negedge clk);
    chk("reset_ready", req_ready, 4'b0000);
    chk("reset_valid", rsp_valid, 1'b0);
    chk("reset_sum", rsp_sum, 32'h0);
    chk("reset_id", rsp_id, 2'd0);
    chk("reset_cout", rsp_cout, 1'b0);
    @(posedge clk); #3;
    rst_n     = 1'b1;
    req_valid = 4'b0000;

    one_req(32'h0000_0005, 32'h0000_0007, 32'h0000_000c, 1'b0);
    one_req(32'hffff_ffff, 32'h0000_0001, 32'h0000_0000, 1'b1);
    one_req(32'h8000_0000, 32'h8000_0000, 32'h0000_0000, 1'b1);

    // Fresh pointer for the contention sequence.
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;

    for (int i = 0; i < NREQ; i++) set_op(i, 32'(i * 16 + 1), 32'(i * 256));
    @(posedge clk); #1;
    req_valid = 4'b1111;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      chk("contend_ready", req_ready, RR ? (4'b0001 << (k % 4)) : 4'b0001);
      if (k > 0) begin
        chk("contend_valid", rsp_valid, 1'b1);
        chk("contend_id", rsp_id, RR ? 2'((k - 1) % 4) : 2'd0);
        chk("contend_sum", rsp_sum, RR ? 32'(((k - 1) % 4) * 272 + 1) : 32'd1);
      end
      @(posedge clk); #1;
    end
    req_valid = 4'b0000;
    @(negedge clk);
    chk("contend_last_id", rsp_id, RR ? 2'd3 : 2'd0);

    @(posedge clk); #1;
    req_valid = 4'b0010;
    set_op(1, 32'h11, 32'h22);
    @(negedge clk);
    chk("bp_first_ready", req_ready, 4'b0010);
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    req_valid = 4'b0011;
    set_op(1, 32'h100, 32'h1);
    set_op(0, 32'h7, 32'h9);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("bp_hold_valid", rsp_valid, 1'b1);
      chk("bp_hold_id", rsp_id, 2'd1);
      chk("bp_hold_sum", rsp_sum, 32'h33);
      chk("bp_hold_ready", req_ready, 4'b0000);
      @(posedge clk); #1;
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    chk("bp_release_ready", req_ready, 4'b0001);
    @(posedge clk); #1;
    req_valid = 4'b0000;
    rsp_ready = 1'b0;
    @(negedge clk);
    chk("bp_nobubble_valid", rsp_valid, 1'b1);
    chk("bp_nobubble_id", rsp_id, 2'd0);
    chk("bp_nobubble_sum", rsp_sum, 32'h10);

    @(posedge clk); #3;
    rst_n     = 1'b0;
    req_valid = 4'b1111;
    #1;
    chk("async_rst_valid", rsp_valid, 1'b0);
    chk("async_rst_ready", req_ready, 4'b0000);
    @(posedge clk); #3;
    req_valid = 4'b0000;
    rsp_ready = 1'b1;
    rst_n     = 1'b1;
    repeat (2) begin
      @(negedge clk);
      chk("post_rst_valid", rsp_valid, 1'b0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
